reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised successor to the processor's 8x8 register file.
- One synchronous write port and two combinational read ports (A/B), for two-operand ALU instructions.
- Optional same-cycle write-to-read forwarding.
- Per-register busy scoreboard for multi-cycle producers, plus flattened tap buses for debug and bench observation.

Parameters:
- WIDTH, 8, data width of each register.
- DEPTH, 8, number of registers; must be at least 2.
- ADDR_W, 3, address width; must equal clog2(DEPTH). An elaboration check fails otherwise.
- BYPASS, 1, 1 = forward the same-cycle write to the read ports; 0 = reads show registered contents only.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- ReadAddrA  in  ADDR_W  read port A address.
- ReadDataA  out  WIDTH  read port A data (combinational).
- ReadBusyA  out  1  busy bit of register ReadAddrA.
- ReadAddrB  in  ADDR_W  read port B address.
- ReadDataB  out  WIDTH  read port B data (combinational).
- ReadBusyB  out  1  busy bit of register ReadAddrB.
- WriteAddr  in  ADDR_W  write address.
- WriteData  in  WIDTH  write data.
- WriteEnable  in  1  write strobe, sampled on the Clk rising edge.
- MarkAddr  in  ADDR_W  register to mark busy.
- MarkEnable  in  1  set busy[MarkAddr] on the Clk rising edge.
- RegTap  out  DEPTH*WIDTH  all registers, register i at bits [i*WIDTH +: WIDTH].
- BusyTap  out  DEPTH  busy bit i at bit i.

Behaviour:
- State: Register[0..DEPTH-1] (WIDTH bits each) and busy[0..DEPTH-1]. All state updates on the Clk rising edge only; no latches.
- Reset (Reset=0 at an edge):
  - Register[i] <= i, truncated to WIDTH; busy[i] <= 0 for all i.
  - Reset has priority over write and mark in that cycle.
  - During the Reset=0 cycle, reads and taps still show pre-edge state. Reset values appear after the edge.
- Write: WriteEnable=1 and WriteAddr<DEPTH at an edge:
  - Register[WriteAddr] <= WriteData.
  - busy[WriteAddr] <= 0.
  - WriteAddr>=DEPTH: the write is dropped; no state changes.
- Mark: MarkEnable=1 and MarkAddr<DEPTH at an edge: busy[MarkAddr] <= 1. Out-of-range MarkAddr is ignored.
- Write and mark to the same address in the same cycle:
  - Data is written.
  - busy ends at 1, because the mark represents a newer producer.
- Write and mark to different addresses in the same cycle: both take effect.
- Mark on an already-busy register: no change.
- Write to a non-busy register: still writes; busy stays 0.
- Read, for each port X in {A, B}:
  - ReadAddrX>=DEPTH: ReadDataX=0 and ReadBusyX=0.
  - BYPASS=1 and WriteEnable=1 and WriteAddr==ReadAddrX (in range): ReadDataX=WriteData and ReadBusyX=0, combinationally. Mark is never forwarded.
  - Otherwise: ReadDataX=Register[ReadAddrX] and ReadBusyX=busy[ReadAddrX].
- Read latency: 0 cycles; both ports are independent and may use the same address.
- Write latency: visible on the registered path one cycle after the edge; visible in the same cycle through the bypass.
- RegTap and BusyTap always show registered state and are never bypassed.
- Reset values of outputs after the first reset edge:
  - RegTap = {i}.
  - BusyTap = 0.
  - ReadData and ReadBusy follow the addresses per the rules above.
- Before the first reset, state is undefined; the bench must apply Reset=0 for at least 1 cycle.

Test Plan:
- Reset=0 for 2 cycles, then release. Expect RegTap register i = i (0..7), BusyTap=8'h00, ReadAddrA=5 gives ReadDataA=8'h05.
- BYPASS=1: WriteEnable=1, WriteAddr=3, WriteData=8'hA5, ReadAddrA=3, ReadAddrB=4.
  - Same cycle: ReadDataA=8'hA5, ReadDataB=8'h04.
  - Next cycle with WriteEnable=0: ReadDataA=8'hA5.
- BYPASS=0, same stimulus: ReadDataA=8'h03 in the write cycle and 8'hA5 the cycle after.
- MarkEnable=1, MarkAddr=6.
  - Next cycle: BusyTap=8'h40 and ReadBusyB=1 for ReadAddrB=6.
  - Then write 8'h3C to address 6: BusyTap=8'h00 and ReadDataB=8'h3C.
- Same cycle: WriteEnable=1, WriteAddr=2, WriteData=8'h11, MarkEnable=1, MarkAddr=2. Next cycle: Register[2]=8'h11 and busy[2]=1.
- Reset priority and out-of-range handling:
  - WriteEnable=1, WriteAddr=1, WriteData=8'hFF with Reset=0 in the same cycle: Register[1]=8'h01 after the edge.
  - DEPTH=6, ADDR_W=3: a write to address 7 leaves RegTap unchanged; ReadAddrA=7 gives ReadDataA=0, ReadBusyA=0.

Source files
------------

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - parametrised 1W/2R register file with write forwarding and busy scoreboard
module reg_file_mp #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int BYPASS = 1
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [ADDR_W-1:0]      ReadAddrA,
   output logic [WIDTH-1:0]       ReadDataA,
   output logic                   ReadBusyA,
   input  logic [ADDR_W-1:0]      ReadAddrB,
   output logic [WIDTH-1:0]       ReadDataB,
   output logic                   ReadBusyB,
   input  logic [ADDR_W-1:0]      WriteAddr,
   input  logic [WIDTH-1:0]       WriteData,
   input  logic                   WriteEnable,
   input  logic [ADDR_W-1:0]      MarkAddr,
   input  logic                   MarkEnable,
   output logic [DEPTH*WIDTH-1:0] RegTap,
   output logic [DEPTH-1:0]       BusyTap
);

   // Address space may be larger than DEPTH; anything at or above it is out of range.
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   generate
      if (DEPTH < 2 || ADDR_W != $clog2(DEPTH)) begin : g_bad_param
         $error("reg_file_mp: DEPTH must be >= 2 and ADDR_W must equal clog2(DEPTH)");
      end
   endgenerate

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0] r_busy;

   logic w_wr_ok;
   logic w_mk_ok;
   logic w_ra_ok;
   logic w_rb_ok;
   logic w_fwd_a;
   logic w_fwd_b;

   assign w_wr_ok = WriteEnable && ({1'b0, WriteAddr} < DEPTH_C);
   assign w_mk_ok = MarkEnable  && ({1'b0, MarkAddr}  < DEPTH_C);
   assign w_ra_ok = {1'b0, ReadAddrA} < DEPTH_C;
   assign w_rb_ok = {1'b0, ReadAddrB} < DEPTH_C;
   assign w_fwd_a = (BYPASS != 0) && w_wr_ok && (WriteAddr == ReadAddrA);
   assign w_fwd_b = (BYPASS != 0) && w_wr_ok && (WriteAddr == ReadAddrB);

   // Register storage: reset loads each register with its own index, writes update one entry.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= WIDTH'(i);
         end
      end else if (w_wr_ok) begin
         r_regs[WriteAddr] <= WriteData;
      end
   end

   // Busy scoreboard: a write retires its producer, a mark (applied last) claims a newer one.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_busy <= '0;
      end else begin
         if (w_wr_ok) begin
            r_busy[WriteAddr] <= 1'b0;
         end
         if (w_mk_ok) begin
            r_busy[MarkAddr] <= 1'b1;
         end
      end
   end

   // Read port A: out-of-range reads zero, forwarded writes report not-busy.
   always_comb begin
      ReadDataA = '0;
      ReadBusyA = 1'b0;
      if (w_ra_ok) begin
         if (w_fwd_a) begin
            ReadDataA = WriteData;
         end else begin
            ReadDataA = r_regs[ReadAddrA];
            ReadBusyA = r_busy[ReadAddrA];
         end
      end
   end

   // Read port B: identical to port A, fully independent.
   always_comb begin
      ReadDataB = '0;
      ReadBusyB = 1'b0;
      if (w_rb_ok) begin
         if (w_fwd_b) begin
            ReadDataB = WriteData;
         end else begin
            ReadDataB = r_regs[ReadAddrB];
            ReadBusyB = r_busy[ReadAddrB];
         end
      end
   end

   // Debug taps always reflect registered state, never the forwarding path.
   always_comb begin
      RegTap = '0;
      for (int i = 0; i < DEPTH; i++) begin
         RegTap[i*WIDTH +: WIDTH] = r_regs[i];
      end
      BusyTap = r_busy;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed table-driven bench for reg_file_mp
module tb_reg_file_mp;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [2:0] ReadAddrA, ReadAddrB, WriteAddr, MarkAddr;
   logic [7:0] WriteData;
   logic       WriteEnable, MarkEnable;

   logic [7:0]  da_b, db_b, da_n, db_n, da_6, db_6;
   logic        ba_b, bb_b, ba_n, bb_n, ba_6, bb_6;
   logic [63:0] tap_b, tap_n;
   logic [47:0] tap_6;
   logic [7:0]  bt_b, bt_n;
   logic [5:0]  bt_6;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   reg_file_mp #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .BYPASS(1)) u_byp (
      .Clk(Clk), .Reset(Reset),
      .ReadAddrA(ReadAddrA), .ReadDataA(da_b), .ReadBusyA(ba_b),
      .ReadAddrB(ReadAddrB), .ReadDataB(db_b), .ReadBusyB(bb_b),
      .WriteAddr(WriteAddr), .WriteData(WriteData), .WriteEnable(WriteEnable),
      .MarkAddr(MarkAddr), .MarkEnable(MarkEnable),
      .RegTap(tap_b), .BusyTap(bt_b)
   );

   reg_file_mp #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .BYPASS(0)) u_nobyp (
      .Clk(Clk), .Reset(Reset),
      .ReadAddrA(ReadAddrA), .ReadDataA(da_n), .ReadBusyA(ba_n),
      .ReadAddrB(ReadAddrB), .ReadDataB(db_n), .ReadBusyB(bb_n),
      .WriteAddr(WriteAddr), .WriteData(WriteData), .WriteEnable(WriteEnable),
      .MarkAddr(MarkAddr), .MarkEnable(MarkEnable),
      .RegTap(tap_n), .BusyTap(bt_n)
   );

   reg_file_mp #(.WIDTH(8), .DEPTH(6), .ADDR_W(3), .BYPASS(1)) u_d6 (
      .Clk(Clk), .Reset(Reset),
      .ReadAddrA(ReadAddrA), .ReadDataA(da_6), .ReadBusyA(ba_6),
      .ReadAddrB(ReadAddrB), .ReadDataB(db_6), .ReadBusyB(bb_6),
      .WriteAddr(WriteAddr), .WriteData(WriteData), .WriteEnable(WriteEnable),
      .MarkAddr(MarkAddr), .MarkEnable(MarkEnable),
      .RegTap(tap_6), .BusyTap(bt_6)
   );

   typedef struct {
      logic       we;
      logic [2:0] wa;
      logic [7:0] wd;
      logic       me;
      logic [2:0] ma;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [7:0] da;
      logic [7:0] db;
      logic       ba;
      logic       bb;
      logic [7:0] nda;
      logic [7:0] bt;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      //            we  wa    wd     me  ma    ra    rb    da     db     ba  bb  nda    bt
      vecs[0]  = '{1, 3'd3, 8'hA5, 0, 3'd0, 3'd3, 3'd4, 8'hA5, 8'h04, 0, 0, 8'h03, 8'h00};
      vecs[1]  = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd3, 3'd4, 8'hA5, 8'h04, 0, 0, 8'hA5, 8'h00};
      vecs[2]  = '{0, 3'd0, 8'h00, 1, 3'd6, 3'd6, 3'd6, 8'h06, 8'h06, 0, 0, 8'h06, 8'h00};
      vecs[3]  = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd6, 8'h00, 8'h06, 0, 1, 8'h00, 8'h40};
      vecs[4]  = '{1, 3'd6, 8'h3C, 0, 3'd0, 3'd6, 3'd5, 8'h3C, 8'h05, 0, 0, 8'h06, 8'h40};
      vecs[5]  = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd1, 3'd6, 8'h01, 8'h3C, 0, 0, 8'h01, 8'h00};
      vecs[6]  = '{1, 3'd2, 8'h11, 1, 3'd2, 3'd2, 3'd7, 8'h11, 8'h07, 0, 0, 8'h02, 8'h00};
      vecs[7]  = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd2, 3'd2, 8'h11, 8'h11, 1, 1, 8'h11, 8'h04};
      vecs[8]  = '{1, 3'd0, 8'h5A, 1, 3'd7, 3'd7, 3'd0, 8'h07, 8'h5A, 0, 0, 8'h07, 8'h04};
      vecs[9]  = '{0, 3'd0, 8'h00, 1, 3'd7, 3'd7, 3'd0, 8'h07, 8'h5A, 1, 0, 8'h07, 8'h84};
      vecs[10] = '{1, 3'd2, 8'h22, 0, 3'd0, 3'd0, 3'd2, 8'h5A, 8'h22, 0, 0, 8'h5A, 8'h84};
      vecs[11] = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd2, 3'd7, 8'h22, 8'h07, 0, 1, 8'h22, 8'h80};
      vecs[12] = '{1, 3'd4, 8'h44, 0, 3'd0, 3'd4, 3'd4, 8'h44, 8'h44, 0, 0, 8'h04, 8'h80};
      vecs[13] = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd4, 3'd3, 8'h44, 8'hA5, 0, 0, 8'h44, 8'h80};

      Reset = 1'b0; WriteEnable = 1'b0; MarkEnable = 1'b0;
      WriteAddr = 3'd0; WriteData = 8'h00; MarkAddr = 3'd0;
      ReadAddrA = 3'd5; ReadAddrB = 3'd0;
      tick();
      tick();
      Reset = 1'b1;
      #1;
      chk("reset_regtap",    tap_b, 64'h0706050403020100);
      chk("reset_busytap",   {56'd0, bt_b}, 64'h0);
      chk("reset_read_a5",   {56'd0, da_b}, 64'h05);
      chk("reset_regtap_d6", {16'd0, tap_6}, 64'h050403020100);

      for (int i = 0; i < 14; i++) begin
         WriteEnable = vecs[i].we; WriteAddr = vecs[i].wa; WriteData = vecs[i].wd;
         MarkEnable  = vecs[i].me; MarkAddr  = vecs[i].ma;
         ReadAddrA   = vecs[i].ra; ReadAddrB = vecs[i].rb;
         #2;
         chk($sformatf("v%0d_da", i),  {56'd0, da_b}, {56'd0, vecs[i].da});
         chk($sformatf("v%0d_db", i),  {56'd0, db_b}, {56'd0, vecs[i].db});
         chk($sformatf("v%0d_ba", i),  {63'd0, ba_b}, {63'd0, vecs[i].ba});
         chk($sformatf("v%0d_bb", i),  {63'd0, bb_b}, {63'd0, vecs[i].bb});
         chk($sformatf("v%0d_nda", i), {56'd0, da_n}, {56'd0, vecs[i].nda});
         chk($sformatf("v%0d_bt", i),  {56'd0, bt_b}, {56'd0, vecs[i].bt});
         tick();
      end
      WriteEnable = 1'b0; MarkEnable = 1'b0;
      #1;
      chk("table_regtap",    tap_b, 64'h073C0544A522015A);
      chk("table_regtap_nb", tap_n, 64'h073C0544A522015A);
      chk("table_regtap_d6", {16'd0, tap_6}, 64'h0544A522015A);
      chk("table_busy_d6",   {58'd0, bt_6}, 64'h0);

      // Out-of-range write/mark/read on the 6-deep instance
      WriteEnable = 1'b1; WriteAddr = 3'd7; WriteData = 8'hEE;
      MarkEnable = 1'b1; MarkAddr = 3'd6; ReadAddrA = 3'd7; ReadAddrB = 3'd6;
      #2;
      chk("d6_oor_da", {56'd0, da_6}, 64'h0);
      chk("d6_oor_ba", {63'd0, ba_6}, 64'h0);
      chk("d6_oor_db", {56'd0, db_6}, 64'h0);
      tick();
      WriteEnable = 1'b0; MarkEnable = 1'b0;
      #1;
      chk("d6_oor_tap",  {16'd0, tap_6}, 64'h0544A522015A);
      chk("d6_oor_busy", {58'd0, bt_6}, 64'h0);
      chk("byp_w7_tap",  tap_b, 64'hEE3C0544A522015A);
      chk("byp_busy_m6", {56'd0, bt_b}, 64'h40);

      // Reset has priority over a simultaneous write; pre-edge state still visible
      Reset = 1'b0; WriteEnable = 1'b1; WriteAddr = 3'd1; WriteData = 8'hFF;
      MarkEnable = 1'b1; MarkAddr = 3'd3; ReadAddrA = 3'd1; ReadAddrB = 3'd6;
      #2;
      chk("rst_pre_tap",  tap_b, 64'hEE3C0544A522015A);
      chk("rst_pre_busy", {56'd0, bt_b}, 64'h40);
      tick();
      Reset = 1'b1; WriteEnable = 1'b0; MarkEnable = 1'b0;
      #1;
      chk("rst_prio_da",   {56'd0, da_b}, 64'h01);
      chk("rst_prio_da_n", {56'd0, da_n}, 64'h01);
      chk("rst_prio_tap",  tap_b, 64'h0706050403020100);
      chk("rst_prio_busy", {56'd0, bt_b}, 64'h0);
      chk("rst_prio_bb",   {63'd0, bb_b}, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
